// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
// Imported by regfile_scoreboard and regfile_mp.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on alloc, cleared on writeback or flush.
// Exports both the registered busy vector and its next state for the read bypass.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NUM_WR = 1,
    localparam int AW     = addr_width(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic                 flush,
    output logic [NREGS-1:0]     busy_q,
    output logic [NREGS-1:0]     busy_d
);

    // Statements run from lowest to highest priority, so each later one overrides.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and the default
        // copy on the first line guarantees no latch is inferred.
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with registered reads and integrated busy scoreboard.
// Define RF_WR_BYPASS_EN to forward same-cycle write data and busy next-state to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 1,
    localparam int AW     = addr_width(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr_ip,
    output logic [NUM_RD*XLEN-1:0]   rd_data_op,
    output logic [NUM_RD-1:0]        rd_busy_op,
    input  logic [NUM_WR-1:0]        wr_en_ip,
    input  logic [NUM_WR*AW-1:0]     wr_addr_ip,
    input  logic [NUM_WR*XLEN-1:0]   wr_data_ip,
    input  logic                     alloc_en_ip,
    input  logic [AW-1:0]            alloc_addr_ip,
    input  logic                     flush_ip
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0][XLEN-1:0] regs_d;
    logic [NREGS-1:0][XLEN-1:0] regs_rd;
    logic [NREGS-1:0]           busy_q;
    logic [NREGS-1:0]           busy_d;
    logic [NREGS-1:0]           busy_rd;
    logic [NUM_RD*XLEN-1:0]     rd_data_d;
    logic [NUM_RD-1:0]          rd_busy_d;

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en_ip),
        .wr_addr    (wr_addr_ip),
        .alloc_en   (alloc_en_ip),
        .alloc_addr (alloc_addr_ip),
        .flush      (flush_ip),
        .busy_q     (busy_q),
        .busy_d     (busy_d)
    );

    // Ports are applied in ascending order, so the highest-index writer of an address wins.
    always_comb begin
        regs_d = regs;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_ip[p] && wr_addr_ip[p*AW +: AW] != AW'(ZERO_REG)) begin
                regs_d[wr_addr_ip[p*AW +: AW]] = wr_data_ip[p*XLEN +: XLEN];
            end
        end
    end

    // NOTE: the storage array is reset because reset must clear architectural
    // state; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            regs <= regs_d;
        end
    end

`ifdef RF_WR_BYPASS_EN
    assign regs_rd = regs_d;
    assign busy_rd = busy_d;
`else
    logic unused_busy_d;
    assign regs_rd       = regs;
    assign busy_rd       = busy_q;
    // Next-state busy is only consumed by the bypass path.
    assign unused_busy_d = ^busy_d;
`endif

    // Row 0 is never written and its busy bit is forced low, so x0 reads as zero/not busy.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_d[p*XLEN +: XLEN] = regs_rd[rd_addr_ip[p*AW +: AW]];
            rd_busy_d[p]              = busy_rd[rd_addr_ip[p*AW +: AW]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_op <= '0;
            rd_busy_op <= '0;
        end else begin
            rd_data_op <= rd_data_d;
            rd_busy_op <= rd_busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboarded testbench for regfile_mp (NUM_RD=4, NUM_WR=2) with a reference model.
// Expectations follow RF_WR_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    typedef struct {
        logic [NUM_RD*XLEN-1:0] data;
        logic [NUM_RD-1:0]      busy;
        string                  name;
        bit                     dir_en;
        bit                     dir_busy;
        int                     dir_port;
        logic [XLEN-1:0]        dir_val;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic [AW-1:0]          rd_addr [NUM_RD];
    logic [NUM_WR-1:0]      wr_en;
    logic [AW-1:0]          wr_addr [NUM_WR];
    logic [XLEN-1:0]        wr_data [NUM_WR];
    logic                   alloc_en;
    logic [AW-1:0]          alloc_addr;
    logic                   flush;

    logic [NUM_RD*AW-1:0]   rd_addr_ip;
    logic [NUM_RD*XLEN-1:0] rd_data_op;
    logic [NUM_RD-1:0]      rd_busy_op;
    logic [NUM_WR*AW-1:0]   wr_addr_ip;
    logic [NUM_WR*XLEN-1:0] wr_data_ip;

    assign rd_addr_ip = {rd_addr[3], rd_addr[2], rd_addr[1], rd_addr[0]};
    assign wr_addr_ip = {wr_addr[1], wr_addr[0]};
    assign wr_data_ip = {wr_data[1], wr_data[0]};

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_addr_ip    (rd_addr_ip),
        .rd_data_op    (rd_data_op),
        .rd_busy_op    (rd_busy_op),
        .wr_en_ip      (wr_en),
        .wr_addr_ip    (wr_addr_ip),
        .wr_data_ip    (wr_data_ip),
        .alloc_en_ip   (alloc_en),
        .alloc_addr_ip (alloc_addr),
        .flush_ip      (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference state: architectural registers and busy bits.
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];
    logic [XLEN-1:0] n_reg  [NREGS];
    bit              n_busy [NREGS];

    // Pending directed expectation attached to the next step.
    bit              pend_en;
    bit              pend_busy;
    int              pend_port;
    logic [XLEN-1:0] pend_val;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic clr();
        for (int p = 0; p < NUM_RD; p++) rd_addr[p] = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_addr[p] = '0;
            wr_data[p] = '0;
        end
        wr_en      = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        flush      = 1'b0;
    endtask

    task automatic wr(input int port, input int a, input logic [XLEN-1:0] d);
        wr_en[port]   = 1'b1;
        wr_addr[port] = AW'(a);
        wr_data[port] = d;
    endtask

    task automatic rd(input int port, input int a);
        rd_addr[port] = AW'(a);
    endtask

    task automatic alloc(input int a);
        alloc_en   = 1'b1;
        alloc_addr = AW'(a);
    endtask

    task automatic expect_data(input int port, input logic [XLEN-1:0] v);
        pend_en = 1'b1; pend_busy = 1'b0; pend_port = port; pend_val = v;
    endtask

    task automatic expect_busy(input int port, input bit b);
        pend_en = 1'b1; pend_busy = 1'b1; pend_port = port; pend_val = XLEN'(b);
    endtask

    // Apply the current inputs for one cycle: predict the read response, queue it, advance the model.
    task automatic step(input string name);
        exp_t e;
        bit   written;
        n_reg = m_reg;
        for (int p = 0; p < NUM_WR; p++)
            if (wr_en[p] && wr_addr[p] != 0) n_reg[wr_addr[p]] = wr_data[p];
        for (int r = 0; r < NREGS; r++) begin
            written = 1'b0;
            for (int p = 0; p < NUM_WR; p++)
                if (wr_en[p] && int'(wr_addr[p]) == r) written = 1'b1;
            if (flush)                                          n_busy[r] = 1'b0;
            else if (alloc_en && int'(alloc_addr) == r && r != 0) n_busy[r] = 1'b1;
            else if (written)                                   n_busy[r] = 1'b0;
            else                                                n_busy[r] = m_busy[r];
        end
        for (int p = 0; p < NUM_RD; p++) begin
`ifdef RF_WR_BYPASS_EN
            e.data[p*XLEN +: XLEN] = n_reg[rd_addr[p]];
            e.busy[p]              = n_busy[rd_addr[p]];
`else
            e.data[p*XLEN +: XLEN] = m_reg[rd_addr[p]];
            e.busy[p]              = m_busy[rd_addr[p]];
`endif
            if (rd_addr[p] == 0) begin
                e.data[p*XLEN +: XLEN] = '0;
                e.busy[p]              = 1'b0;
            end
        end
        e.name     = name;
        e.dir_en   = pend_en;
        e.dir_busy = pend_busy;
        e.dir_port = pend_port;
        e.dir_val  = pend_val;
        pend_en    = 1'b0;
        exp_q.push_back(e);
        m_reg  = n_reg;
        m_busy = n_busy;
        @(negedge clk);
        clr();
    endtask

    task automatic do_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        check({name, " data"}, rd_data_op, '0);
        check({name, " busy"}, 128'(rd_busy_op), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int pick_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREGS - 1));
        return int'($urandom_range(0, 7));
    endfunction

    // Monitor: the registered read response appears after every active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, " data"}, rd_data_op, e.data);
                check({e.name, " busy"}, 128'(rd_busy_op), 128'(e.busy));
                if (e.dir_en) begin
                    if (e.dir_busy)
                        check({e.name, " port busy"}, 128'(rd_busy_op[e.dir_port]), 128'(e.dir_val[0]));
                    else
                        check({e.name, " port data"}, 128'(rd_data_op[e.dir_port*XLEN +: XLEN]),
                              128'(e.dir_val));
                end
            end
        end
    end

    initial begin
        pend_en = 1'b0; pend_busy = 1'b0; pend_port = 0; pend_val = '0;
        rst_n = 1'b1;
        clr();
        model_reset();
        do_reset("power-on reset");
        @(negedge clk);

        // Basic write then read, and x0 stays zero.
        wr(0, 3, 32'hDEADBEEF);                  step("write x3");
        rd(1, 3); expect_data(1, 32'hDEADBEEF);  step("read x3");
        wr(1, 0, 32'h1); rd(0, 0);               step("write x0");
        rd(0, 0); expect_data(0, 32'h0);         step("read x0");

        // Same-cycle read-after-write.
        wr(0, 7, 32'h5);                         step("write x7 old");
`ifdef RF_WR_BYPASS_EN
        wr(0, 7, 32'h1234); rd(0, 7); expect_data(0, 32'h1234); step("raw x7");
`else
        wr(0, 7, 32'h1234); rd(0, 7); expect_data(0, 32'h5);    step("raw x7");
`endif
        rd(0, 7); expect_data(0, 32'h1234);      step("reread x7");

        // Two writers to one register: port 1 wins.
        wr(0, 9, 32'hAAAA); wr(1, 9, 32'hBBBB);  step("conflict x9");
        rd(3, 9); expect_data(3, 32'hBBBB);      step("read x9");

        // Scoreboard priority.
        alloc(4); rd(2, 4);                      step("alloc x4");
        rd(2, 4); expect_busy(2, 1'b1);          step("busy x4 set");
        alloc(4); wr(0, 4, 32'h44);              step("alloc+write x4");
        rd(2, 4); expect_busy(2, 1'b1);          step("busy x4 kept");
        wr(1, 4, 32'h45);                        step("write x4");
        rd(2, 4); expect_busy(2, 1'b0);          step("busy x4 cleared");
        alloc(6);                                step("alloc x6");
        alloc(8);                                step("alloc x8");
        rd(1, 8); expect_busy(1, 1'b1);          step("busy x8 set");
        flush = 1'b1; rd(0, 6);                  step("flush");
        rd(0, 6); expect_busy(0, 1'b0);          step("x6 after flush");
        rd(1, 8); expect_busy(1, 1'b0);          step("x8 after flush");
        alloc(0);                                step("alloc x0");
        rd(0, 0); expect_busy(0, 1'b0);          step("x0 never busy");

        // Mid-run reset wipes data and busy state.
        wr(0, 5, 32'h55); alloc(10);             step("write x5");
        rd(0, 5); rd(1, 3); rd(2, 10);           step("read before reset");
        do_reset("mid-run reset");
        rd(0, 5); expect_data(0, 32'h0);         step("x5 after reset");
        rd(2, 10); expect_busy(2, 1'b0);         step("x10 after reset");

        // Randomised multi-port traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            for (int p = 0; p < NUM_RD; p++) rd(p, pick_addr());
            for (int p = 0; p < NUM_WR; p++)
                if ($urandom_range(0, 1) == 1) wr(p, pick_addr(), $urandom);
            if ($urandom_range(0, 9) < 3) alloc(pick_addr());
            flush = ($urandom_range(0, 39) == 0);
            step("random");
        end

        @(negedge clk);
        @(negedge clk);
        check("queue drained", 128'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
